fetch_queue: RTL

Dual-issue fetch stage for the superscalar MIPS pipeline. It owns the fetch PC, drives the word address into the combinational instruction memory and captures the two sequential instruction words that memory returns (address and address+4) into a small circular instruction queue. The dual decode stage drains the queue 0, 1 or 2 instructions per cycle. A taken branch or jump from downstream flushes the queue and redirects the PC.

---
 rtl/fetch_queue.sv | 119 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Dual-issue fetch stage: owns the fetch PC, captures two sequential words per
// cycle from instruction memory into a circular queue drained by dual decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rd,
    input  logic [31:0]              imem_rd2,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic [1:0]               deq_cnt,
    output logic [31:0]              dec_instr0,
    output logic [31:0]              dec_instr1,
    output logic [31:0]              dec_pc0,
    output logic [31:0]              dec_pc1,
    output logic                     dec_valid0,
    output logic                     dec_valid1,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] CNT_ZERO  = '0;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_TWO   = CW'(2);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ZERO  = '0;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   epc_q   [DEPTH];

    logic [1:0]    deq_eff;
    logic [CW-1:0] pops;
    logic [CW-1:0] free;
    logic [CW-1:0] pushes;
    logic          push0;
    logic          push1;
    logic [PW-1:0] head1;
    logic [PW-1:0] tail1;

    assign head1 = head_q + PTR_ONE;
    assign tail1 = tail_q + PTR_ONE;

    always_comb begin
        deq_eff = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
        pops    = (CW'(deq_eff) > count_q) ? count_q : CW'(deq_eff);
        // Push size comes from pre-pop occupancy; slots freed this cycle are reused next cycle.
        free    = CNT_DEPTH - count_q;
        push0   = !redirect && (free != CNT_ZERO);
        push1   = !redirect && (free >= CNT_TWO);
        pushes  = push1 ? CNT_TWO : (push0 ? CNT_ONE : CNT_ZERO);

        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (redirect) begin
            pc_d    = redirect_pc & ~32'h0000_0003;
            head_d  = PTR_ZERO;
            tail_d  = PTR_ZERO;
            count_d = CNT_ZERO;
        end else begin
            pc_d    = pc_q + (32'(pushes) << 2);
            head_d  = head_q + pops[PW-1:0];
            tail_d  = tail_q + pushes[PW-1:0];
            count_d = count_q + pushes - pops;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            head_q  <= PTR_ZERO;
            tail_q  <= PTR_ZERO;
            count_q <= CNT_ZERO;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: queue storage has no reset; entries are only observed behind the count-derived valids.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push0) begin
                instr_q[tail_q] <= imem_rd;
                epc_q[tail_q]   <= pc_q;
            end
            if (push1) begin
                instr_q[tail1] <= imem_rd2;
                epc_q[tail1]   <= pc_q + 32'd4;
            end
        end
    end

    assign imem_addr  = pc_q;
    assign dec_instr0 = instr_q[head_q];
    assign dec_pc0    = epc_q[head_q];
    assign dec_instr1 = instr_q[head1];
    assign dec_pc1    = epc_q[head1];
    assign dec_valid0 = (count_q != CNT_ZERO);
    assign dec_valid1 = (count_q >= CNT_TWO);
    assign count      = count_q;

endmodule
